switch_arbiter: RTL and testbench

SWITCH_ARBITER -- requirements
Module: switch_arbiter

---
 rtl/switch_arbiter.sv | 151 +++++++++++++++
 tb/tb_switch_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_arbiter.sv
// Round-robin arbiter granting one input port at a time the output FIFO write port for a whole frame.
// Optional stall watchdog enabled by defining SWITCH_ARB_TIMEOUT_EN.
module switch_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic                            fifo_full,
    output logic                            fifo_write_enable,
    output logic [DATA_WIDTH-1:0]           fifo_write_data,
    output logic [NUM_PORTS-1:0]            grant,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                 state_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [PW-1:0]          gidx_q;
    logic [PW-1:0]          last_ptr_q;
    logic                   pick_valid_s;
    logic [PW-1:0]          pick_idx_s;
    logic [NUM_PORTS-1:0]   in_ready_s;
    logic                   beat_s;
    logic                   last_s;
    logic                   timeout_hit_s;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search: first requester strictly after the previous owner.
    always_comb begin
        int cand;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand         = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(last_ptr_q) + k) % NUM_PORTS;
            if (!pick_valid_s && in_valid[cand]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = PW'(cand);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Handshake for the owning port only; backpressure comes straight from the FIFO.
    always_comb begin
        if (state_q == XFER && !fifo_full) begin
            in_ready_s = grant_q;
        end else begin
            in_ready_s = '0;
        end
        beat_s = |(in_valid & in_ready_s);
        last_s = |(in_last & grant_q);
    end

    assign in_ready          = in_ready_s;
    assign fifo_write_enable = beat_s;
    assign fifo_write_data   = in_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    assign grant             = grant_q;
    assign busy              = (state_q == XFER);

`ifdef SWITCH_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] stall_q;
    logic          timeout_err_q;

    // In XFER with the FIFO open and no beat, the owner is the one stalling.
    always_comb begin
        timeout_hit_s = (state_q == XFER) && !fifo_full && !beat_s &&
                        (stall_q == CW'(TIMEOUT_CYCLES - 1));
    end

    assign timeout_err = timeout_err_q;
`else
    // Without the watchdog a frame is only ended by its last beat.
    always_comb begin
        timeout_hit_s = 1'b0;
    end

    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with frame ownership, priority pointer and stall watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            last_ptr_q    <= PW'(NUM_PORTS - 1);
`ifdef SWITCH_ARB_TIMEOUT_EN
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef SWITCH_ARB_TIMEOUT_EN
            timeout_err_q <= timeout_hit_s;
            if (state_q != XFER || beat_s || fifo_full || timeout_hit_s) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q + 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        state_q <= XFER;
                        grant_q <= onehot(pick_idx_s);
                        gidx_q  <= pick_idx_s;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                XFER: begin
                    if ((beat_s && last_s) || timeout_hit_s) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        last_ptr_q <= gidx_q;
                    end else begin
                        state_q <= XFER;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter: per-cycle check against a frame-level ownership model,
// plus literal expectations for beat order, grant order and stall behaviour.
module tb_switch_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     in_valid;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_ready;
    logic              fifo_full;
    logic              fifo_write_enable;
    logic [DW-1:0]     fifo_write_data;
    logic [NP-1:0]     grant;
    logic              busy;
    logic              timeout_err;

    switch_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_ready          (in_ready),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .grant             (grant),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // source frames per port
    logic [DW-1:0] sdat  [NP][32];
    logic          slast [NP][32];
    int            shead [NP];
    int            stail [NP];
    logic [NP-1:0] vmask;
    logic [NP-1:0] took;

    // observation logs
    logic [DW-1:0] blog[$];
    int            glog_idx[$];
    int            glog_cyc[$];
    int            to_cnt;
    int            g3_stall;
    logic [NP-1:0] prev_grant;

    // model state
    int   m_own;
    int   m_last;
    int   m_stall;
    logic m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_beats(input string name, input logic [DW-1:0] e[$]);
        chk({name, "_count"}, blog.size(), e.size());
        for (int i = 0; i < e.size() && i < blog.size(); i++) chk(name, blog[i], e[i]);
    endtask

    task automatic chk_grants(input string name, input int e[$]);
        chk({name, "_count"}, glog_idx.size(), e.size());
        for (int i = 0; i < e.size() && i < glog_idx.size(); i++) chk(name, glog_idx[i], e[i]);
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (shead[p] < stail[p] && vmask[p]) begin
                in_valid[p]          = 1'b1;
                in_data[p*DW +: DW]  = sdat[p][shead[p]];
                in_last[p]           = slast[p][shead[p]];
            end else begin
                in_valid[p]          = 1'b0;
                in_data[p*DW +: DW]  = '0;
                in_last[p]           = 1'b0;
            end
        end
    endtask

    task automatic push(input int p, input logic [DW-1:0] d, input logic l);
        sdat[p][stail[p]]  = d;
        slast[p][stail[p]] = l;
        stail[p]++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (took[p]) shead[p]++;
        drive();
    endtask

    task automatic clear_logs();
        blog.delete();
        glog_idx.delete();
        glog_cyc.delete();
        to_cnt   = 0;
        g3_stall = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        fifo_full = 1'b0;
        vmask     = '1;
        for (int p = 0; p < NP; p++) begin
            shead[p] = 0;
            stail[p] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic run_until_log(input string name, input int n, input int budget);
        int k = 0;
        while (blog.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({name, "_bound"}, (blog.size() >= n), 1);
    endtask

    // Per-cycle compare against the ownership model, then advance the model.
    always @(negedge clk) begin
        logic [NP-1:0] eg;
        logic [NP-1:0] er;
        logic          ebeat;
        cyc++;
        took = in_valid & in_ready;
        if (reset) begin
            m_own   = -1;
            m_last  = NP - 1;
            m_stall = 0;
            m_to    = 1'b0;
            took    = '0;
            chk("reset_outputs", {grant, in_ready, busy, fifo_write_enable, timeout_err}, 0);
            prev_grant = '0;
        end else begin
            eg    = (m_own >= 0) ? (NP'(1) << m_own) : '0;
            er    = (m_own >= 0 && !fifo_full) ? eg : '0;
            ebeat = (m_own >= 0) && in_valid[m_own] && !fifo_full;
            chk("grant", grant, eg);
            chk("busy", busy, (m_own >= 0));
            chk("in_ready", in_ready, er);
            chk("fifo_we", fifo_write_enable, ebeat);
            chk("timeout_err", timeout_err, m_to);
            if (ebeat) chk("fifo_wdata", fifo_write_data, in_data[m_own*DW +: DW]);

            if (fifo_write_enable) blog.push_back(fifo_write_data);
            if (grant != '0 && prev_grant == '0) begin
                for (int p = 0; p < NP; p++) if (grant[p]) glog_idx.push_back(p);
                glog_cyc.push_back(cyc);
            end
            if (timeout_err) to_cnt++;
            if (grant == 4'b1000 && !fifo_write_enable) g3_stall++;
            prev_grant = grant;

            m_to = 1'b0;
            if (m_own < 0) begin
                for (int k = 1; k <= NP; k++) begin
                    if (m_own < 0 && in_valid[(m_last + k) % NP]) m_own = (m_last + k) % NP;
                end
            end else if (ebeat) begin
                m_stall = 0;
                if (in_last[m_own]) begin
                    m_last = m_own;
                    m_own  = -1;
                end
            end else begin
`ifdef SWITCH_ARB_TIMEOUT_EN
                if (fifo_full) m_stall = 0;
                else begin
                    m_stall++;
                    if (m_stall == TO) begin
                        m_to    = 1'b1;
                        m_last  = m_own;
                        m_own   = -1;
                        m_stall = 0;
                    end
                end
`endif
            end
        end
    end

    initial begin
        logic [DW-1:0] eb[$];
        int            eg[$];
        clk       = 1'b0;
        reset     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        fifo_full = 1'b0;
        vmask     = '1;
        took      = '0;
        for (int p = 0; p < NP; p++) begin
            shead[p] = 0;
            stail[p] = 0;
        end
        clear_logs();

        // reset state
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);

        // two simultaneous 3-beat frames on ports 0 and 2
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        drive();
        run_until_log("two_frames", 6, 40);
        eb = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
        chk_beats("two_frames_data", eb);
        eg = '{0, 2};
        chk_grants("two_frames_grant", eg);
        if (glog_cyc.size() == 2) chk("two_frames_gap", glog_cyc[1] - glog_cyc[0], 4);

        // continuous single-beat frames on every port
        do_reset();
        push(0, 8'h01, 1'b1); push(0, 8'h05, 1'b1);
        push(1, 8'h02, 1'b1); push(2, 8'h03, 1'b1); push(3, 8'h04, 1'b1);
        drive();
        run_until_log("rr", 5, 40);
        eg = '{0, 1, 2, 3, 0};
        chk_grants("rr_order", eg);
        for (int i = 1; i < glog_cyc.size(); i++) chk("rr_spacing", glog_cyc[i] - glog_cyc[i-1], 2);
        eb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        chk_beats("rr_data", eb);

        // FIFO full for 5 cycles mid-frame on port 1
        do_reset();
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0); push(1, 8'h13, 1'b1);
        drive();
        run_until_log("full_pre", 1, 20);
        fifo_full = 1'b1;
        repeat (5) begin
            #2;
            chk("full_ready", in_ready, 0);
            chk("full_we", fifo_write_enable, 0);
            chk("full_busy", busy, 1);
            step();
        end
        fifo_full = 1'b0;
        run_until_log("full_post", 4, 20);
        eb = '{8'h10, 8'h11, 8'h12, 8'h13};
        chk_beats("full_data", eb);

        // reset during beat 2 of a 4-beat frame on port 2
        do_reset();
        push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
        drive();
        run_until_log("midrst_pre", 1, 20);
        chk("midrst_grant_before", grant, 4'b0100);
        #1 reset = 1'b1;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_we", fifo_write_enable, 0);
        do_reset();
        push(3, 8'h50, 1'b1);
        push(0, 8'h60, 1'b1);
        drive();
        run_until_log("midrst_post", 2, 20);
        eg = '{0, 3};
        chk_grants("midrst_order", eg);
        eb = '{8'h60, 8'h50};
        chk_beats("midrst_data", eb);

        // port 3 owner stops sending; port 0 waits
        do_reset();
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        drive();
        run_until_log("stall_pre", 1, 20);
        vmask[3] = 1'b0;
        push(0, 8'h40, 1'b1);
        drive();
`ifdef SWITCH_ARB_TIMEOUT_EN
        begin
            int k = 0;
            while (to_cnt == 0 && k < 40) begin
                step();
                k++;
            end
        end
        repeat (6) step();
        chk("to_pulses", to_cnt, 1);
        chk("to_stall_cycles", g3_stall, TO);
        eg = '{3, 0};
        chk_grants("to_order", eg);
        eb = '{8'h30, 8'h40};
        chk_beats("to_data", eb);
`else
        repeat (110) step();
        chk("noto_pulses", to_cnt, 0);
        chk("noto_stall_cycles", g3_stall, 110);
        chk("noto_grant", grant, 4'b1000);
        chk("noto_busy", busy, 1);
        eg = '{3};
        chk_grants("noto_order", eg);
`endif
        do_reset();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
